seq_detector_10010_mealy_2bit_overlapping: RTL and testbench

//  - Serial bit-stream pattern detector for "10010" (first-received bit first), Mealy style.
//  - Pulses dout in the same cycle the final '0' of the pattern is on din.
//  - Overlapping detection: the trailing "10" of a match is the start of the next candidate.
//  - Leaf block sampling one serial data line per clock. It feeds a downstream event/flag consumer.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_detector_10010_mealy_2bit_overlapping.sv | 44 ++++
 tb/tb_seq_detector_10010_mealy_2bit_overlapping.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_det_pkg
// Brief  : State encoding shared by the "10010" Mealy sequence detector.
// Rev    : 1.0  initial release
// ============================================================================
package seq_det_pkg;

    // Each state names the longest prefix of "10010" matched so far
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_detector_10010_mealy_2bit_overlapping.sv
`default_nettype none
// ============================================================================
// Module : seq_detector_10010_mealy_2bit_overlapping
// Brief  : Overlapping Mealy detector for serial pattern "10010", zero latency.
// Rev    : 1.0  initial release
// ============================================================================
module seq_detector_10010_mealy_2bit_overlapping
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = din ? S1 : S0;
            S1:      w_next = din ? S1 : S2;
            S2:      w_next = din ? S1 : S3;
            S3:      w_next = din ? S4 : S0;
            // A detect leaves the trailing "10" as the next candidate's start
            S4:      w_next = din ? S1 : S2;
            default: w_next = S0;
        endcase
    end

    // Gating with reset keeps dout clean before the first edge defines the state
    assign dout = (r_state == S4) && !din && !reset;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_10010_mealy_2bit_overlapping.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_detector_10010_mealy_2bit_overlapping
// Brief  : Scoreboard bench; reference model is a sliding window of past bits.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seq_detector_10010_mealy_2bit_overlapping;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0;
    logic dout;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle_no     = 0;

    bit exp_q[$];
    bit hist_q[$];

    seq_detector_10010_mealy_2bit_overlapping dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    // Expected dout: the last four accepted bits followed by the current bit spell 10010
    function automatic bit model_expect(input bit r, input bit d);
        bit [4:0] w;
        if (r || hist_q.size() < 4) return 1'b0;
        w = {hist_q[hist_q.size()-4], hist_q[hist_q.size()-3],
             hist_q[hist_q.size()-2], hist_q[hist_q.size()-1], d};
        return (w == 5'b10010);
    endfunction

    // Apply one bit at the falling edge (or time 0) and wait for the next falling edge
    task automatic drive(input bit r, input bit d);
        reset = r;
        din   = d;
        exp_q.push_back(model_expect(r, d));
        if (r) begin
            hist_q.delete();
        end else begin
            hist_q.push_back(d);
            if (hist_q.size() > 4) void'(hist_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drive_seq(input logic [31:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) drive(1'b0, bits[i]);
    endtask

    // Monitor: dout is valid every cycle; sample 1 unit before each rising edge
    initial begin
        bit e;
        #4;
        forever begin
            cycle_no++;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL scoreboard_empty cycle %0d: dout=%b with no expected entry", cycle_no, dout);
            end else begin
                e = exp_q.pop_front();
                n_compared++;
                if (dout !== e) begin
                    n_mismatched++;
                    $display("FAIL dout cycle %0d (reset=%b din=%b): got %b, expected %b",
                             cycle_no, reset, din, dout, e);
                end
            end
            #10;
        end
    end

    initial begin
        int wait_cnt;
        // Reset held across the first two rising edges with both din values
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);

        drive_seq(32'b10010, 5);
        drive_seq(32'b10011, 5);
        drive_seq(32'b10010010, 8);
        drive(1'b1, 1'b0);
        drive_seq(32'b10010_10011_10010_010, 18);
        drive(1'b1, 1'b1);
        drive_seq(32'b10010010010, 11);
        drive(1'b1, 1'b0);
        drive_seq(32'b001010010, 9);
        // Reset mid-pattern discards the partial "1001"
        drive_seq(32'b1001, 4);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive_seq(32'b10010, 5);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0)
                drive(1'b1, 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 9) == 0)
                drive_seq(32'b10010, 5);
            else
                drive(1'b0, 1'($urandom_range(0, 1)));
        end

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
